param_timer_bank: RTL

Parametrised successor to the time-parameter register block. It holds NUM_PARAMS programmable time parameters, each with a power-on default, and drives the selected parameter (optionally doubled) on a registered output. It adds an integrated countdown timer that loads the selected interval and decrements on an external tick enable. It sits between the user reprogramming inputs and the controller FSM (traffic-light or alarm sequencer), which consumes `expired`.

---
 rtl/param_timer_bank_pkg.sv | 19 +
 rtl/param_timer_bank_if.sv | 31 +++
 rtl/param_regfile.sv | 68 ++++++
 rtl/param_timer_bank.sv | 116 +++++++++++
 4 files changed

// File: rtl/param_timer_bank_pkg.sv
// Shared types and defaults for the programmable time-parameter bank.
// Imported by the register file and the countdown top level.
package param_timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int NUM_PARAMS_DEF = 4;
  localparam int SEL_W_DEF      = 2;
  localparam int VAL_W_DEF      = 4;
  localparam int OUT_W_DEF      = 5;

  localparam logic [15:0] DEFAULTS_DEF =
    {4'd9, 4'd2, 4'd3, 4'd6};

endpackage

// File: rtl/param_timer_bank_if.sv
// User-side bundle of the timer bank: reprogram, read select,
// timer control and the registered results.
interface param_timer_bank_if #(
  parameter int SEL_W = 2,
  parameter int VAL_W = 4,
  parameter int OUT_W = 5
);
  logic [SEL_W-1:0] time_param_sel;
  logic [VAL_W-1:0] time_value;
  logic             reprogram;
  logic [SEL_W-1:0] interval;
  logic             double_sel;
  logic             start;
  logic             tick;
  logic [OUT_W-1:0] value;
  logic [OUT_W-1:0] remaining;
  logic             busy;
  logic             expired;

  modport master (
    output time_param_sel, time_value, reprogram,
    output interval, double_sel, start, tick,
    input  value, remaining, busy, expired
  );

  modport slave (
    input  time_param_sel, time_value, reprogram,
    input  interval, double_sel, start, tick,
    output value, remaining, busy, expired
  );
endinterface

// File: rtl/param_regfile.sv
// Parameter register array: default-on-zero writes, scaled read
// exposed both combinationally (timer load) and registered.
module param_regfile
  import param_timer_bank_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter logic [NUM_PARAMS*VAL_W-1:0] DEFAULTS =
    DEFAULTS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [SEL_W-1:0] wsel,
  input  logic [VAL_W-1:0] wdata,
  input  logic [SEL_W-1:0] rsel,
  input  logic             dbl,
  output logic [OUT_W-1:0] load_val,
  output logic [OUT_W-1:0] value
);

  logic [VAL_W-1:0] params_q [NUM_PARAMS];
  logic [VAL_W-1:0] params_d [NUM_PARAMS];
  logic [VAL_W-1:0] rd_raw;
  logic [OUT_W-1:0] value_q;
  logic [OUT_W-1:0] value_d;

  always_comb begin
    for (int i = 0; i < NUM_PARAMS; i++) begin
      params_d[i] = params_q[i];
      if (we && wsel == SEL_W'(i)) begin
        params_d[i] = (wdata == '0)
          ? DEFAULTS[i*VAL_W +: VAL_W]
          : wdata;
      end
    end
  end

  // Reads use pre-write contents; unmatched selects read as 0.
  always_comb begin
    rd_raw = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (rsel == SEL_W'(i)) rd_raw = params_q[i];
    end
    load_val = {{(OUT_W-VAL_W){1'b0}}, rd_raw};
    if (dbl) load_val = load_val << 1;
    value_d = load_val;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        params_q[i] <= DEFAULTS[i*VAL_W +: VAL_W];
      end
      value_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        params_q[i] <= params_d[i];
      end
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/param_timer_bank.sv
// Programmable time-parameter bank with an integrated countdown
// timer that loads the selected interval and counts on tick.
module param_timer_bank
  import param_timer_bank_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter logic [NUM_PARAMS*VAL_W-1:0] DEFAULTS =
    DEFAULTS_DEF
) (
  input logic          clock,
  input logic          reset,
  param_timer_bank_if.slave bus
);

  logic [OUT_W-1:0] load_val;
  logic [OUT_W-1:0] value;
  logic             load_ok;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;

  param_regfile #(
    .NUM_PARAMS (NUM_PARAMS),
    .SEL_W      (SEL_W),
    .VAL_W      (VAL_W),
    .OUT_W      (OUT_W),
    .DEFAULTS   (DEFAULTS)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we       (bus.reprogram),
    .wsel     (bus.time_param_sel),
    .wdata    (bus.time_value),
    .rsel     (bus.interval),
    .dbl      (bus.double_sel),
    .load_val (load_val),
    .value    (value)
  );

  assign load_ok = (load_val != '0);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    expired_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && load_ok) begin
          remaining_d = load_val;
          busy_d      = 1'b1;
          state_d     = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (bus.start) begin
          // A start with nothing to load abandons the count.
          if (load_ok) begin
            remaining_d = load_val;
          end else begin
            remaining_d = '0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (bus.tick) begin
          remaining_d = remaining_q - OUT_W'(1);
          if (remaining_q == OUT_W'(1)) begin
            busy_d    = 1'b0;
            expired_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        remaining_d = '0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
        if (bus.start && load_ok) begin
          remaining_d = load_val;
          busy_d      = 1'b1;
          state_d     = ST_COUNT;
        end
      end
      default: begin
        remaining_d = '0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      expired_q   <= expired_d;
    end
  end

  assign bus.value     = value;
  assign bus.remaining = remaining_q;
  assign bus.busy      = busy_q;
  assign bus.expired   = expired_q;

endmodule
